// File: rtl/flags_register_pkg.sv
// Shared definitions for the FLAGS register slice: bit positions, flag-update
// opcodes, the ALU operation enum and small helpers for reserved-bit handling.
package flags_register_pkg;

  localparam int CF_IDX = 0;
  localparam int PF_IDX = 2;
  localparam int AF_IDX = 4;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int TF_IDX = 8;
  localparam int IF_IDX = 9;
  localparam int DF_IDX = 10;
  localparam int OF_IDX = 11;

  localparam logic [15:0] FLAGS_RESET      = 16'hF002;
  localparam logic [15:0] FLAGS_WRITABLE   = 16'h0FD5;
  localparam logic [15:0] FLAGS_FIXED_ONES = 16'hF002;
  // SAHF touches only SF, ZF, AF, PF and CF.
  localparam logic [15:0] LOW_LOAD_MASK    = 16'h00D5;

  typedef enum logic [3:0] {
    FOP_NONE      = 4'd0,
    FOP_CLC       = 4'd1,
    FOP_STC       = 4'd2,
    FOP_CMC       = 4'd3,
    FOP_CLD       = 4'd4,
    FOP_STD       = 4'd5,
    FOP_CLI       = 4'd6,
    FOP_STI       = 4'd7,
    FOP_LOAD_FULL = 4'd8,
    FOP_LOAD_LOW  = 4'd9,
    FOP_INT_ENTRY = 4'd10
  } flag_op_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBB = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_CMP = 4'd7,
    ALU_INC = 4'd8,
    ALU_DEC = 4'd9,
    ALU_NEG = 4'd10,
    ALU_SHL = 4'd11,
    ALU_SHR = 4'd12,
    ALU_SAR = 4'd13
  } alu_op_e;

  // Expand the {OF,SF,ZF,AF,PF,CF} commit mask onto FLAGS bit positions.
  function automatic logic [15:0] mask_to_flags(input logic [5:0] mask);
    logic [15:0] res;
    res         = 16'h0000;
    res[CF_IDX] = mask[0];
    res[PF_IDX] = mask[1];
    res[AF_IDX] = mask[2];
    res[ZF_IDX] = mask[3];
    res[SF_IDX] = mask[4];
    res[OF_IDX] = mask[5];
    return res;
  endfunction

  function automatic logic [15:0] fix_reserved(input logic [15:0] value);
    return (value & FLAGS_WRITABLE) | FLAGS_FIXED_ONES;
  endfunction

endpackage

// File: rtl/flags_register_jcc_cond_eval.sv
// Jcc condition decoder: evaluates the 16 x86 condition codes against FLAGS.
module jcc_cond_eval
  import flags_register_pkg::*;
(
  input  logic [15:0] flags,
  input  logic [3:0]  cond_sel,
  output logic        cond_true
);

  logic base_s;

  // Even codes test the base condition; odd codes are its complement.
  always_comb begin
    base_s = 1'b0;
    case (cond_sel[3:1])
      3'd0:    base_s = flags[OF_IDX];
      3'd1:    base_s = flags[CF_IDX];
      3'd2:    base_s = flags[ZF_IDX];
      3'd3:    base_s = flags[CF_IDX] | flags[ZF_IDX];
      3'd4:    base_s = flags[SF_IDX];
      3'd5:    base_s = flags[PF_IDX];
      3'd6:    base_s = flags[SF_IDX] ^ flags[OF_IDX];
      3'd7:    base_s = (flags[SF_IDX] ^ flags[OF_IDX]) | flags[ZF_IDX];
      default: base_s = 1'b0;
    endcase
    cond_true = base_s ^ cond_sel[0];
  end

endmodule

// File: rtl/flags_register.sv
// Architectural FLAGS register with ALU commit, explicit flag ops, STI
// interrupt shadow and Jcc condition evaluation.
module flags_register
  import flags_register_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] alu_flags,
  input  logic        alu_update,
  input  logic [5:0]  upd_mask,
  input  logic [3:0]  flag_op,
  input  logic [15:0] load_data,
  input  logic        instr_done,
  output logic [15:0] flags,
  input  logic [3:0]  cond_sel,
  output logic        cond_true,
  output logic        int_enable
);

  logic [15:0] flags_r;
  logic [15:0] alu_merged_s;
  logic [15:0] op_applied_s;
  logic [15:0] flags_next_s;
  logic [15:0] alu_mask_s;
  logic [1:0]  shadow_r;
  logic [1:0]  shadow_next_s;
  logic        int_enable_r;
  flag_op_e    op_s;

  assign op_s       = flag_op_e'(flag_op);
  assign alu_mask_s = mask_to_flags(upd_mask);

  // Next FLAGS: ALU commit first, then flag_op layered on top so it wins.
  always_comb begin
    alu_merged_s = flags_r;
    if (alu_update) begin
      alu_merged_s = (flags_r & ~alu_mask_s) | (alu_flags & alu_mask_s);
    end else begin
      alu_merged_s = flags_r;
    end

    op_applied_s = alu_merged_s;
    case (op_s)
      FOP_CLC:       op_applied_s[CF_IDX] = 1'b0;
      FOP_STC:       op_applied_s[CF_IDX] = 1'b1;
      FOP_CMC:       op_applied_s[CF_IDX] = ~flags_r[CF_IDX];
      FOP_CLD:       op_applied_s[DF_IDX] = 1'b0;
      FOP_STD:       op_applied_s[DF_IDX] = 1'b1;
      FOP_CLI:       op_applied_s[IF_IDX] = 1'b0;
      FOP_STI:       op_applied_s[IF_IDX] = 1'b1;
      FOP_LOAD_FULL: op_applied_s = load_data;
      FOP_LOAD_LOW:  op_applied_s = (alu_merged_s & ~LOW_LOAD_MASK) | (load_data & LOW_LOAD_MASK);
      FOP_INT_ENTRY: begin
        op_applied_s[IF_IDX] = 1'b0;
        op_applied_s[TF_IDX] = 1'b0;
      end
      default:       op_applied_s = alu_merged_s;
    endcase

    flags_next_s = fix_reserved(op_applied_s);
  end

  // STI shadow: interrupts stay masked until the instruction after STI retires.
  always_comb begin
    shadow_next_s = shadow_r;
    if (op_s == FOP_STI) begin
      shadow_next_s = instr_done ? 2'd1 : 2'd2;
    end else if ((op_s == FOP_CLI) || (op_s == FOP_INT_ENTRY) || (op_s == FOP_LOAD_FULL)) begin
      shadow_next_s = 2'd0;
    end else if (instr_done && (shadow_r != 2'd0)) begin
      shadow_next_s = shadow_r - 2'd1;
    end else begin
      shadow_next_s = shadow_r;
    end
  end

  // State registers; int_enable is precomputed from next state so it aligns with flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_r      <= FLAGS_RESET;
      shadow_r     <= 2'd0;
      int_enable_r <= 1'b0;
    end else begin
      flags_r      <= flags_next_s;
      shadow_r     <= shadow_next_s;
      int_enable_r <= flags_next_s[IF_IDX] & (shadow_next_s == 2'd0);
    end
  end

  assign flags      = flags_r;
  assign int_enable = int_enable_r;

  jcc_cond_eval u_cond (
    .flags     (flags_r),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_flags_register.sv
// Directed bench for flags_register with a behavioural FLAGS/shadow model
// checked every cycle plus literal expectations for the key scenarios.
module tb_flags_register;
  import flags_register_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] alu_flags;
  logic        alu_update;
  logic [5:0]  upd_mask;
  logic [3:0]  flag_op;
  logic [15:0] load_data;
  logic        instr_done;
  logic [15:0] flags;
  logic [3:0]  cond_sel;
  logic        cond_true;
  logic        int_enable;

  always #5 clk = ~clk;

  flags_register dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_flags  (alu_flags),
    .alu_update (alu_update),
    .upd_mask   (upd_mask),
    .flag_op    (flag_op),
    .load_data  (load_data),
    .instr_done (instr_done),
    .flags      (flags),
    .cond_sel   (cond_sel),
    .cond_true  (cond_true),
    .int_enable (int_enable)
  );

  // Model state
  logic [15:0] m_flags;
  int          m_shadow;
  logic        m_int;
  bit          model_valid = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          pos [0:5] = '{0, 2, 4, 6, 7, 11};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_model(input logic [15:0] f, input logic [3:0] cs);
    logic cf, pf, zf, sf, of_b, c;
    cf = f[0]; pf = f[2]; zf = f[6]; sf = f[7]; of_b = f[11];
    case (cs)
      4'h0: c = of_b;            4'h1: c = !of_b;
      4'h2: c = cf;              4'h3: c = !cf;
      4'h4: c = zf;              4'h5: c = !zf;
      4'h6: c = cf || zf;        4'h7: c = !(cf || zf);
      4'h8: c = sf;              4'h9: c = !sf;
      4'hA: c = pf;              4'hB: c = !pf;
      4'hC: c = sf != of_b;      4'hD: c = sf == of_b;
      4'hE: c = (sf != of_b) || zf;
      default: c = !((sf != of_b) || zf);
    endcase
    return c;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_valid) begin
      chk("flags", flags, m_flags);
      chk("cond_true", {15'd0, cond_true}, {15'd0, cond_model(m_flags, cond_sel)});
      chk("int_enable", {15'd0, int_enable}, {15'd0, m_int});
    end
  end

  task automatic cyc(input logic rn, input logic au, input logic [5:0] m, input logic [15:0] af,
                     input logic [3:0] op, input logic [15:0] ld, input logic id, input logic [3:0] cs);
    logic [15:0] nf;
    reset_n = rn; alu_update = au; upd_mask = m; alu_flags = af;
    flag_op = op; load_data = ld; instr_done = id; cond_sel = cs;
    @(posedge clk);
    if (!rn) begin
      m_flags = 16'hF002;
      m_shadow = 0;
      model_valid = 1'b1;
    end else begin
      nf = m_flags;
      if (au) for (int i = 0; i < 6; i++) if (m[i]) nf[pos[i]] = af[pos[i]];
      case (op)
        FOP_CLC:       nf[0] = 1'b0;
        FOP_STC:       nf[0] = 1'b1;
        FOP_CMC:       nf[0] = !m_flags[0];
        FOP_CLD:       nf[10] = 1'b0;
        FOP_STD:       nf[10] = 1'b1;
        FOP_CLI:       nf[9] = 1'b0;
        FOP_STI:       nf[9] = 1'b1;
        FOP_LOAD_FULL: nf = (ld & 16'h0FD5) | 16'hF002;
        FOP_LOAD_LOW:  for (int i = 0; i < 5; i++) nf[pos[i]] = ld[pos[i]];
        FOP_INT_ENTRY: begin nf[9] = 1'b0; nf[8] = 1'b0; end
        default: ;
      endcase
      m_flags = nf;
      if (op == FOP_STI) m_shadow = id ? 1 : 2;
      else if (op == FOP_CLI || op == FOP_INT_ENTRY || op == FOP_LOAD_FULL) m_shadow = 0;
      else if (id && m_shadow > 0) m_shadow = m_shadow - 1;
    end
    m_int = m_flags[9] && (m_shadow == 0);
    #1;
  endtask

  task automatic idle(input logic [3:0] cs, input logic id);
    cyc(1'b1, 1'b0, 6'h00, 16'h0000, FOP_NONE, 16'h0000, id, cs);
  endtask

  task automatic alu(input logic [5:0] m, input logic [15:0] af, input logic [3:0] op, input logic [3:0] cs);
    cyc(1'b1, 1'b1, m, af, op, 16'h0000, 1'b0, cs);
  endtask

  task automatic fop(input logic [3:0] op, input logic [15:0] ld, input logic id);
    cyc(1'b1, 1'b0, 6'h00, 16'h0000, op, ld, id, 4'h4);
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    reset_n = 1'b0; alu_update = 1'b0; upd_mask = 6'h00; alu_flags = 16'h0000;
    flag_op = 4'h0; load_data = 16'h0000; instr_done = 1'b0; cond_sel = 4'h4;

    // Reset
    cyc(1'b0, 1'b0, 6'h00, 16'h0000, FOP_NONE, 16'h0000, 1'b0, 4'h4);
    cyc(1'b0, 1'b0, 6'h00, 16'h0000, FOP_NONE, 16'h0000, 1'b0, 4'h4);
    lit("reset_flags", flags, 16'hF002);
    lit("reset_cond4", {15'd0, cond_true}, 16'h0000);
    lit("reset_int", {15'd0, int_enable}, 16'h0000);

    // Full ALU commit
    alu(6'h3F, 16'h0041, FOP_NONE, 4'h4);
    lit("alu_full", flags, 16'hF043);
    lit("alu_cond4", {15'd0, cond_true}, 16'h0001);
    idle(4'h2, 1'b0);
    lit("alu_cond2", {15'd0, cond_true}, 16'h0001);

    // INC/DEC mask keeps CF
    alu(6'h3F, 16'h0001, FOP_NONE, 4'h4);
    lit("cf_only", flags, 16'hF003);
    alu(6'h3E, 16'h0040, FOP_NONE, 4'h4);
    lit("inc_rule", flags, 16'hF043);

    // CMC beats concurrent ALU write of CF
    fop(FOP_CLC, 16'h0000, 1'b0);
    lit("clc", flags, 16'hF042);
    alu(6'h01, 16'h0000, FOP_CMC, 4'h2);
    lit("cmc_wins", flags, 16'hF043);
    alu(6'h3F, 16'hFFFF, FOP_CLC, 4'h0);
    lit("clc_merge", flags, 16'hF8D6);

    // Loads
    fop(FOP_LOAD_FULL, 16'h0000, 1'b0);
    lit("load_full0", flags, 16'hF002);
    fop(FOP_LOAD_LOW, 16'hFFD5, 1'b0);
    lit("load_low", flags, 16'hF0D7);

    // STI shadow
    fop(FOP_STI, 16'h0000, 1'b0);
    lit("sti_shadow", {15'd0, int_enable}, 16'h0000);
    idle(4'h4, 1'b1);
    lit("shadow_1", {15'd0, int_enable}, 16'h0000);
    idle(4'h4, 1'b1);
    lit("shadow_0", {15'd0, int_enable}, 16'h0001);
    fop(FOP_STI, 16'h0000, 1'b0);
    idle(4'h4, 1'b1);
    fop(FOP_CLI, 16'h0000, 1'b0);
    lit("cli_mid", {15'd0, int_enable}, 16'h0000);
    fop(FOP_STI, 16'h0000, 1'b1);
    lit("sti_done", {15'd0, int_enable}, 16'h0000);
    idle(4'h4, 1'b1);
    lit("sti_done_next", {15'd0, int_enable}, 16'h0001);
    fop(FOP_STD, 16'h0000, 1'b0);
    lit("std", flags, 16'hF6D7);
    fop(FOP_CLD, 16'h0000, 1'b0);
    fop(FOP_INT_ENTRY, 16'h0000, 1'b0);
    lit("int_entry", flags, 16'hF0D7);
    fop(FOP_LOAD_FULL, 16'h0300, 1'b0);
    lit("load_tf_if", flags, 16'hF302);
    lit("load_int", {15'd0, int_enable}, 16'h0001);
    fop(FOP_INT_ENTRY, 16'h0000, 1'b1);
    lit("int_entry2", flags, 16'hF002);

    // Signed conditions with SF=1, OF=0, ZF=0
    fop(FOP_LOAD_FULL, 16'h0080, 1'b0);
    idle(4'hC, 1'b0); lit("cond_L", {15'd0, cond_true}, 16'h0001);
    idle(4'hD, 1'b0); lit("cond_GE", {15'd0, cond_true}, 16'h0000);
    idle(4'hE, 1'b0); lit("cond_LE", {15'd0, cond_true}, 16'h0001);
    idle(4'hF, 1'b0); lit("cond_G", {15'd0, cond_true}, 16'h0000);

    // Condition sweep over several flag patterns
    foreach (pos[k]) begin
      fop(FOP_LOAD_FULL, (16'h0001 << pos[k]) | (k[0] ? 16'h0040 : 16'h0000), 1'b0);
      for (int c = 0; c < 16; c++) idle(c[3:0], 1'b0);
    end
    fop(FOP_LOAD_FULL, 16'hFFFF, 1'b0);
    lit("load_full_ones", flags, 16'hFFD7);

    // Reset overrides concurrent activity
    cyc(1'b0, 1'b1, 6'h3F, 16'hFFFF, FOP_STI, 16'hFFFF, 1'b1, 4'h4);
    lit("reset_override", flags, 16'hF002);
    lit("reset_override_int", {15'd0, int_enable}, 16'h0000);
    idle(4'h4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
